// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   IM_ADDR_W     : width of the IM SRAM word address
//   IM_WEB_READ   : byte write enables (active-low) for a pure read
//   fetch_entry_t : one buffered instruction with its PC
package fetch_pkg;

    localparam int unsigned IM_ADDR_W   = 14;
    localparam logic [3:0]  IM_WEB_READ = 4'hF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write an entry (dropped when full and not popping)
//   i_pop          : remove the head entry (ignored when empty)
//   i_flush        : empty the FIFO; wins over push and pop
//   o_head         : head entry, all zero while empty
//   o_full, o_empty, o_count : occupancy
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // Gate the head so stale storage never shows while empty.
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/im_fetch_buffer.sv
// Instruction prefetch stage between the CPU fetch port and the IM SRAM.
// Issues sequential word reads, absorbs the one-cycle SRAM latency and
// buffers {pc, inst} pairs for the CPU.
// Ports:
//   i_clk, i_rst_n                    : clock, asynchronous active-low reset
//   i_redirect_valid, i_redirect_pc   : flush and restart fetch
//   o_inst_valid/data/pc, i_inst_ready: CPU-side valid/ready handshake
//   o_im_cs/oe/web/addr/din, i_im_dout: IM SRAM read port
module im_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_redirect_valid,
    input  logic [31:0]          i_redirect_pc,
    output logic                 o_inst_valid,
    output logic [31:0]          o_inst_data,
    output logic [31:0]          o_inst_pc,
    input  logic                 i_inst_ready,
    output logic                 o_im_cs,
    output logic                 o_im_oe,
    output logic [3:0]           o_im_web,
    output logic [IM_ADDR_W-1:0] o_im_addr,
    output logic [31:0]          o_im_din,
    input  logic [31:0]          i_im_dout
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_issue_pc;   // PC of the read whose data is on i_im_dout
    logic        r_pend;
    logic        r_kill;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_inflight;
    logic             w_full;
    logic             w_empty;
    logic             w_issue_ok;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_head;
    fetch_entry_t     w_resp;
    logic             w_unused;

    // Alignment bits of the redirect target are dropped by design.
    assign w_unused = ^i_redirect_pc[1:0];

    // Credit counts buffered plus in-flight entries; a same-cycle pop is not credited.
    assign w_inflight = {1'b0, w_count} + (CNT_W + 1)'(r_pend);
    assign w_issue_ok = ~i_redirect_valid & (w_inflight < (CNT_W + 1)'(DEPTH));

    // Reset only gates the outputs; the flops are held by the async reset.
    assign o_im_cs   = w_issue_ok & i_rst_n;
    assign o_im_oe   = o_im_cs;
    assign o_im_web  = IM_WEB_READ;
    assign o_im_addr = i_rst_n ? r_fetch_pc[IM_ADDR_W+1:2] : '0;
    assign o_im_din  = '0;

    assign w_resp = '{pc: r_issue_pc, inst: i_im_dout};
    // Credit guarantees room whenever a response lands.
    assign w_push = r_pend & ~r_kill & ~w_full;
    assign w_pop  = o_inst_valid & i_inst_ready;

    assign o_inst_valid = ~w_empty;
    assign o_inst_data  = w_head.inst;
    assign o_inst_pc    = w_head.pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= '0;
            r_pend     <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_pend <= w_issue_ok;
            r_kill <= i_redirect_valid;
            if (i_redirect_valid) begin
                r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
            end else if (w_issue_ok) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_issue_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_resp),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_im_fetch_buffer.sv
// Self-checking bench for im_fetch_buffer: an SRAM model, a scoreboard of
// expected {pc} entries pushed on issue and popped on handshake, plus
// per-scenario timing checks.
module tb_im_fetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        im_cs;
    logic        im_oe;
    logic [3:0]  im_web;
    logic [13:0] im_addr;
    logic [31:0] im_din;
    logic [31:0] im_dout = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    im_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_inst_valid     (inst_valid),
        .o_inst_data      (inst_data),
        .o_inst_pc        (inst_pc),
        .i_inst_ready     (inst_ready),
        .o_im_cs          (im_cs),
        .o_im_oe          (im_oe),
        .o_im_web         (im_web),
        .o_im_addr        (im_addr),
        .o_im_din         (im_din),
        .i_im_dout        (im_dout)
    );

    function automatic logic [31:0] mem_f(input logic [13:0] a);
        return {a ^ 14'h2A5A, 4'hC, a};
    endfunction

    // SRAM model: data for a sampled address appears the next cycle; garbage otherwise.
    always @(posedge clk) begin
        if (im_cs) im_dout <= mem_f(im_addr);
        else       im_dout <= $urandom();
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = RESET_PC;
            n_checks++;
            if (im_cs !== 1'b0 || im_oe !== 1'b0 || im_addr !== 14'h0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mon_reset: cs=%b oe=%b addr=%h valid=%b, required 0 0 0 0",
                         im_cs, im_oe, im_addr, inst_valid);
            end
        end else begin
            n_checks++;
            if (im_web !== 4'hF || im_din !== 32'h0 || im_oe !== im_cs) begin
                n_fail++;
                $display("FAIL mon_const: web=%h din=%h oe=%b cs=%b, required F 0 oe==cs",
                         im_web, im_din, im_oe, im_cs);
            end
            if (exp_q.size() >= 2) begin
                n_checks++;
                if (inst_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mon_valid: inst_valid=%b with %0d queued, required 1",
                             inst_valid, exp_q.size());
                end
            end
            if (redirect_valid) begin
                n_checks++;
                if (im_cs !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_redirect_cs: im_cs=%b, required 0", im_cs);
                end
                exp_q.delete();
                exp_pc = redirect_pc & ~32'd3;
            end else begin
                if (im_cs) begin
                    n_checks++;
                    if (im_addr !== exp_pc[15:2] || exp_q.size() >= DEPTH) begin
                        n_fail++;
                        $display("FAIL mon_issue: addr=%h outstanding=%0d, required addr=%h outstanding<%0d",
                                 im_addr, exp_q.size(), exp_pc[15:2], DEPTH);
                    end
                    exp_q.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (inst_valid && inst_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_pop: got pc=%h, required no valid entry", inst_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (inst_pc !== mon_e || inst_data !== mem_f(mon_e[15:2])) begin
                            n_fail++;
                            $display("FAIL mon_pop: got pc=%h data=%h, required pc=%h data=%h",
                                     inst_pc, inst_data, mon_e, mem_f(mon_e[15:2]));
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (im_cs !== 1'b0 || im_addr !== 14'h0 || im_web !== 4'hF || im_din !== 32'h0 ||
            inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: cs=%b addr=%h web=%h din=%h v=%b d=%h pc=%h, required 0 0 F 0 0 0 0",
                     im_cs, im_addr, im_web, im_din, inst_valid, inst_data, inst_pc);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (im_cs !== 1'b1 || im_addr !== RESET_PC[15:2]) begin
            n_fail++;
            $display("FAIL reset_first_issue: cs=%b addr=%h, required 1 %h", im_cs, im_addr, RESET_PC[15:2]);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_c1_valid: got %b, required 0", inst_valid);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_c2_head: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] prev;
        prev = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (inst_valid !== 1'b1 || im_cs !== 1'b1 || (i > 0 && inst_pc !== prev + 32'd4)) begin
                n_fail++;
                $display("FAIL stream_cycle%0d: valid=%b cs=%b pc=%h, required 1 1 %h",
                         i, inst_valid, im_cs, inst_pc, prev + 32'd4);
            end
            prev = inst_pc;
        end
    endtask

    task automatic test_redirect(input logic [31:0] target, input logic [13:0] addr0,
                                 input logic [13:0] addr1, input logic [31:0] pc0);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        inst_ready     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (im_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_R_cs: got %b, required 0", im_cs);
        end
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (im_cs !== 1'b1 || im_addr !== addr0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_R1: cs=%b addr=%h valid=%b, required 1 %h 0",
                     im_cs, im_addr, inst_valid, addr0);
        end
        @(negedge clk);
        n_checks++;
        if (im_addr !== addr1 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_R2: addr=%h valid=%b, required %h 0", im_addr, inst_valid, addr1);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== pc0) begin
            n_fail++;
            $display("FAIL redirect_R3: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, pc0);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== pc0 + 32'd4) begin
            n_fail++;
            $display("FAIL redirect_R4: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, pc0 + 32'd4);
        end
    endtask

    task automatic test_backpressure();
        int          issues;
        int          npop;
        logic [31:0] got [4];
        logic [13:0] first_addr;
        logic        seen;
        @(posedge clk); #1;
        rst_n      = 1'b0;
        inst_ready = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        issues = 0;
        repeat (10) begin
            @(negedge clk);
            if (im_cs) issues++;
        end
        n_checks++;
        if (issues != 4 || inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL bp_fill: issues=%0d valid=%b pc=%h, required 4 1 %h",
                     issues, inst_valid, inst_pc, RESET_PC);
        end
        @(posedge clk); #1 inst_ready = 1'b1;
        npop = 0;
        seen = 1'b0;
        first_addr = 14'h0;
        repeat (6) begin
            @(negedge clk);
            if (inst_valid && npop < 4) begin
                got[npop] = inst_pc;
                npop++;
            end
            if (im_cs && !seen) begin
                first_addr = im_addr;
                seen = 1'b1;
            end
        end
        n_checks++;
        if (npop != 4 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8 || got[3] !== 32'hC) begin
            n_fail++;
            $display("FAIL bp_drain: n=%0d pcs=%h %h %h %h, required 4 0 4 8 c",
                     npop, got[0], got[1], got[2], got[3]);
        end
        n_checks++;
        if (!seen || first_addr !== 14'h4) begin
            n_fail++;
            $display("FAIL bp_resume: seen=%b addr=%h, required 1 0004", seen, first_addr);
        end
    endtask

    task automatic test_redirect_full();
        @(posedge clk); #1 inst_ready = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || im_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_redirect: valid=%b cs=%b, required 1 0", inst_valid, im_cs);
        end
        test_redirect(32'h0000_2000, 14'h0800, 14'h0801, 32'h0000_2000);
    endtask

    task automatic test_reset_mid();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (im_cs !== 1'b0 || im_oe !== 1'b0 || im_addr !== 14'h0 || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_async: cs=%b oe=%b addr=%h v=%b d=%h pc=%h, required all 0",
                     im_cs, im_oe, im_addr, inst_valid, inst_data, inst_pc);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (im_cs !== 1'b1 || im_addr !== RESET_PC[15:2]) begin
            n_fail++;
            $display("FAIL midreset_issue: cs=%b addr=%h, required 1 %h", im_cs, im_addr, RESET_PC[15:2]);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_c1: valid=%b, required 0", inst_valid);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL midreset_c2: valid=%b pc=%h, required 1 %h", inst_valid, inst_pc, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_redirect(32'h0000_1006, 14'h0401, 14'h0402, 32'h0000_1004);
        test_stream();
        test_redirect(32'h0000_FFFC, 14'h3FFF, 14'h0000, 32'h0000_FFFC);
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_stream();
        test_reset_mid();
        test_stream();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im_fetch_buffer.md
# im_fetch_buffer

Instruction prefetch stage between the CPU fetch port and the instruction-memory SRAM_wrapper. It generates sequential word reads into the IM SRAM, absorbs the SRAM's one-cycle read latency, and buffers fetched instructions with their PCs in a small FIFO. The CPU consumes them through a valid/ready handshake and redirects fetch on branches and jumps.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  flush the buffer and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  head entry is valid.
- inst_data  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  CPU accepts the head entry this cycle.
- im_cs  out  1  SRAM chip select; high only in a cycle that issues a read.
- im_oe  out  1  SRAM output enable; equals im_cs.
- im_web  out  4  SRAM byte write enables, active-low; constant 4'hF (read only).
- im_addr  out  14  SRAM word address, fetch_pc[15:2].
- im_din  out  32  SRAM write data; constant 0.
- im_dout  in  32  SRAM read data.

## Operation
- State:
  - fetch_pc (32b).
  - pend flag: a read issued last cycle whose data is on im_dout this cycle.
  - kill flag: drop the pending response.
  - FIFO of {pc, inst} with a count.
- Issue condition: rst high, redirect_valid low, and count + pend < DEPTH. A pop in the same cycle gives no extra credit.
- When a read issues: im_cs=im_oe=1, im_addr=fetch_pc[15:2], pend<=1, and fetch_pc<=fetch_pc+4.
- Response: when pend=1 and kill=0, {pc of issued read, im_dout} is written to the FIFO at the end of that cycle. The buffer registers the issued PC for this purpose.
- Pop: inst_valid && inst_ready removes the head.
- A push and a pop in the same cycle are both performed; count is unchanged.
- Redirect takes priority over all other events in its cycle:
  - The FIFO empties and count<=0.
  - A same-cycle pop or push is discarded.
  - fetch_pc<=redirect_pc & ~3.
  - No read issues in that cycle.
  - kill is set for any response still in flight.
- fetch_pc wraps modulo 2^32. im_addr therefore wraps modulo 64 KiB; this is not an error.
- A redirect while the FIFO is full or empty behaves identically.
- Reset values while rst is low:
  - im_cs=0, im_oe=0, im_web=4'hF, im_addr=0, im_din=0.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - fetch_pc=RESET_PC, FIFO empty, pend=0, kill=0.
- Reset asserted mid-operation aborts any outstanding read. Its data is never written to the FIFO.

## Timing
- SRAM contract: address sampled at the rising edge ending the issue cycle N; im_dout valid throughout cycle N+1.
- Issue in cycle N: FIFO write at the end of N+1, inst_valid visible in N+2. There is no bypass from im_dout to inst_data.
- First cycle after rst deasserts: a read of RESET_PC issues. inst_valid rises two cycles later.
- Redirect in cycle R: issue at R+1, FIFO write at end of R+2, inst_valid with inst_pc=redirect_pc in R+3.
- Steady state with inst_ready held high: one instruction per cycle, PCs consecutive.
- The inst_* outputs come from FIFO registers and have no combinational path from inputs.
- The im_* outputs depend combinationally on redirect_valid and inst-side state only. They never depend on im_dout.

## Structure
- Package fetch_pkg:
  - IM_ADDR_W=14.
  - IM_WEB_READ=4'hF.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop.
- The top of the block holds fetch_pc, the pend/kill flags and the issue logic.

## Test plan
- Reset release with RESET_PC=0 and inst_ready=1 -> im_addr sequence 0,1,2,... one per cycle; inst_pc 0,4,8,... starting 2 cycles after release; im_web always 4'hF.
- inst_ready=0 from reset -> exactly 4 reads issued, then im_cs=0; head stays pc=0. Raising inst_ready drains 4 entries and fetch resumes at pc=0x10.
- Redirect to 0x0000_1006 during full streaming -> no issue that cycle; next issue im_addr=0x401; first inst_pc=0x1004 three cycles after the redirect; no stale PCs appear.
- Redirect in the cycle a response arrives, together with inst_ready=1 -> the response is dropped, count is 0 next cycle, and no pop is counted by the scoreboard.
- fetch_pc=0x0000_FFFC streaming -> im_addr 0x3FFF then 0x0000; inst_pc 0xFFFC then 0x1_0000.
- rst pulsed low for 1 cycle mid-stream with a read pending -> all outputs go to reset values immediately; after release the first inst_pc=RESET_PC.
